dmem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: accepts one load/store request at a time over a

---
 rtl/dmem_responder_pkg.sv | 49 ++++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder_bank.sv | 24 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared size codes, FSM states and lane helpers for the wait-state data-memory responder.
// The size encoding matches the load/store unit (00 word, 01 half, 10 byte).
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_W = 2'b00,
    SIZE_H = 2'b01,
    SIZE_B = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [3:0] byte_enable(size_e size, logic [1:0] off);
    case (size)
      SIZE_W:  return 4'b1111;
      SIZE_H:  return off[1] ? 4'b1100 : 4'b0011;
      SIZE_B:  return 4'b0001 << off;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-aligned store data is replicated so that every enabled lane sees the right bits.
  function automatic logic [31:0] lane_data(size_e size, logic [31:0] wdata);
    case (size)
      SIZE_H:  return {2{wdata[15:0]}};
      SIZE_B:  return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] word, logic [1:0] off, size_e size,
                                              logic lu);
    logic [15:0] half;
    logic [7:0]  bval;
    half = off[1] ? word[31:16] : word[15:0];
    bval = word[{off, 3'b000} +: 8];
    case (size)
      SIZE_H:  return lu ? {16'h0000, half} : {{16{half[15]}}, half};
      SIZE_B:  return lu ? {24'h000000, bval} : {{24{bval[7]}}, bval};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_SIZE = 32,
  parameter int XLEN      = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [1:0]           req_size;
  logic                 req_lu;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_lu,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_lu,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_bank.sv
// Word-organised RAM with per-byte write enables and an asynchronous read of the same word.
module dmem_responder_bank #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY cycles, then commits the
// access and pulses resp_valid. Back-to-back accepts are allowed in the response cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_SIZE   = 32,
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  state_e               state, state_next;
  logic [CW-1:0]        cnt;
  logic                 ready, resp_pulse, accept, commit;
  logic                 lat_we, lat_lu;
  logic [ADDR_SIZE-1:0] lat_addr;
  logic [XLEN-1:0]      lat_wdata;
  size_e                lat_size;
  logic                 cur_we, cur_lu;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic [XLEN-1:0]      cur_wdata;
  size_e                cur_size;
  logic [ADDR_SIZE-3:0] word_idx;
  logic                 acc_err;
  logic [XLEN-1:0]      ram_rdata, rdata_q;
  logic                 err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    resp_pulse = 1'b0;
    case (state)
      IDLE, RESP: begin
        resp_pulse = (state == RESP);
        if (bus.req_valid) state_next = (LATENCY == 1) ? RESP : BUSY;
        else               state_next = IDLE;
      end
      BUSY: begin
        ready = 1'b0;
        if (cnt == CW'(1)) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept         = bus.req_valid && ready;
  assign commit         = (state_next == RESP);
  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_pulse;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_lu    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= SIZE_W;
    end else if (accept) begin
      cnt       <= CW'(LATENCY - 1);
      lat_we    <= bus.req_we;
      lat_lu    <= bus.req_lu;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_size  <= size_e'(bus.req_size);
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
    end
  end

  // With LATENCY=1 the commit edge is the accept edge itself, so the live request is used.
  assign cur_we    = (LATENCY == 1) ? bus.req_we             : lat_we;
  assign cur_lu    = (LATENCY == 1) ? bus.req_lu             : lat_lu;
  assign cur_addr  = (LATENCY == 1) ? bus.req_addr           : lat_addr;
  assign cur_wdata = (LATENCY == 1) ? bus.req_wdata          : lat_wdata;
  assign cur_size  = (LATENCY == 1) ? size_e'(bus.req_size)  : lat_size;
  assign word_idx  = cur_addr[ADDR_SIZE-1:2];

  always_comb begin
    acc_err = 1'b0;
    case (cur_size)
      SIZE_X:  acc_err = 1'b1;
      SIZE_H:  acc_err = cur_addr[0];
      SIZE_W:  acc_err = |cur_addr[1:0];
      default: acc_err = 1'b0;
    endcase
    if ((word_idx >> AW) != '0) acc_err = 1'b1;
  end

  dmem_responder_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .we    (commit && cur_we && !acc_err),
    .be    (byte_enable(cur_size, cur_addr[1:0])),
    .addr  (cur_addr[AW+1:2]),
    .wdata (lane_data(cur_size, cur_wdata)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || cur_we) ? '0
                 : load_extend(ram_rdata, cur_addr[1:0], cur_size, cur_lu);
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven by directed requests; monitors pop
// the expected response queue and check data, error flag and arrival cycle.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst2, rst1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   nid = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  dmem_responder_if #(.ADDR_SIZE(32), .XLEN(32)) bus2 ();
  dmem_responder_if #(.ADDR_SIZE(32), .XLEN(32)) bus1 ();

  dmem_responder #(.ADDR_SIZE(32), .XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );
  dmem_responder #(.ADDR_SIZE(32), .XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s", name);
  endtask

  // Idle drives junk on the request fields so ignored inputs are exercised too.
  task automatic idle(input int sel);
    if (sel == 1) begin
      bus1.req_valid = 1'b0; bus1.req_we = 1'b1; bus1.req_addr = 32'h44;
      bus1.req_wdata = 32'hA5A5A5A5; bus1.req_size = 2'b00; bus1.req_lu = 1'b0;
    end else begin
      bus2.req_valid = 1'b0; bus2.req_we = 1'b1; bus2.req_addr = 32'h44;
      bus2.req_wdata = 32'hA5A5A5A5; bus2.req_size = 2'b00; bus2.req_lu = 1'b0;
    end
  endtask

  task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic lu,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit hold);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    if (sel == 1) begin
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr;
      bus1.req_wdata = wdata; bus1.req_size = size; bus1.req_lu = lu;
    end else begin
      bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = addr;
      bus2.req_wdata = wdata; bus2.req_size = size; bus2.req_lu = lu;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      if ((sel == 1) ? bus1.req_ready : bus2.req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      fail_now($sformatf("d%0d accept timeout addr=%h", sel, addr));
    end else begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + ((sel == 1) ? 1 : 2);
      e.id    = nid++;
      if (sel == 1) q1.push_back(e);
      else          q2.push_back(e);
    end
    @(negedge clk);
    if (!hold) idle(sel);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus2.resp_valid) begin
      if (q2.size() == 0) fail_now("d2 unexpected resp_valid");
      else begin
        e = q2.pop_front();
        check($sformatf("d2 resp#%0d rdata", e.id), bus2.resp_rdata, e.rdata);
        check($sformatf("d2 resp#%0d err", e.id), 32'(bus2.resp_err), 32'(e.err));
        check($sformatf("d2 resp#%0d cycle", e.id), cyc, e.cyc);
      end
    end else if (q2.size() != 0 && cyc > q2[0].cyc) begin
      e = q2.pop_front();
      fail_now($sformatf("d2 resp#%0d missing at cycle %0d", e.id, e.cyc));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus1.resp_valid) begin
      if (q1.size() == 0) fail_now("d1 unexpected resp_valid");
      else begin
        e = q1.pop_front();
        check($sformatf("d1 resp#%0d rdata", e.id), bus1.resp_rdata, e.rdata);
        check($sformatf("d1 resp#%0d err", e.id), 32'(bus1.resp_err), 32'(e.err));
        check($sformatf("d1 resp#%0d cycle", e.id), cyc, e.cyc);
      end
    end else if (q1.size() != 0 && cyc > q1[0].cyc) begin
      e = q1.pop_front();
      fail_now($sformatf("d1 resp#%0d missing at cycle %0d", e.id, e.cyc));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst2 = 1'b1;
    rst1 = 1'b1;
    idle(2);
    idle(1);
    @(negedge clk);
    check("reset d2 req_ready", 32'(bus2.req_ready), 32'd1);
    check("reset d2 resp_valid", 32'(bus2.resp_valid), 32'd0);
    check("reset d2 resp_rdata", bus2.resp_rdata, 32'd0);
    check("reset d2 resp_err", 32'(bus2.resp_err), 32'd0);
    check("reset d1 req_ready", 32'(bus1.req_ready), 32'd1);
    rst2 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // word store/load round trip
    issue(2, 1'b1, 32'h40, 32'h12345678, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'h12345678, 1'b0, 1'b0);

    // byte store into a zeroed word, then signed/unsigned byte loads
    issue(2, 1'b1, 32'h100, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(2, 1'b1, 32'h103, 32'h000000AB, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h103, 32'h0, 2'b10, 1'b0, 32'hFFFFFFAB, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h103, 32'h0, 2'b10, 1'b1, 32'h000000AB, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 32'hAB000000, 1'b0, 1'b0);

    // upper-half store over an existing word
    issue(2, 1'b1, 32'h42, 32'h0000BEEF, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'hBEEF5678, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h42, 32'h0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 32'h0000BEEF, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h40, 32'h0, 2'b01, 1'b0, 32'h00005678, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h41, 32'h0, 2'b10, 1'b1, 32'h00000056, 1'b0, 1'b0);

    // error cases leave memory untouched, including the aliasing out-of-range word
    issue(2, 1'b1, 32'h0, 32'h00000055, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h102, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(2, 1'b1, 32'h41, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(2, 1'b0, 32'h40, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(2, 1'b1, 32'h1000, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(2, 1'b1, 32'h42, 32'hCAFEBABE, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(2, 1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'hBEEF5678, 1'b0, 1'b0);
    issue(2, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h00000055, 1'b0, 1'b0);

    // back-to-back with req_valid held high
    issue(2, 1'b1, 32'h200, 32'h00000011, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(2, 1'b1, 32'h204, 32'h00000022, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(2, 1'b0, 32'h200, 32'h0, 2'b00, 1'b0, 32'h00000011, 1'b0, 1'b1);
    issue(2, 1'b0, 32'h204, 32'h0, 2'b00, 1'b0, 32'h00000022, 1'b0, 1'b0);
    issue(1, 1'b1, 32'h300, 32'h0A0B0C0D, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(1, 1'b1, 32'h300, 32'h00008001, 2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h300, 32'h0, 2'b01, 1'b0, 32'hFFFF8001, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h302, 32'h0, 2'b01, 1'b1, 32'h00000A0B, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h300, 32'h0, 2'b00, 1'b0, 32'h0A0B8001, 1'b0, 1'b0);
    drain();

    // reset while busy drops the store and never responds
    issue(2, 1'b1, 32'h80, 32'h11112222, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    drain();
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h80;
    bus2.req_wdata = 32'hDEADBEEF; bus2.req_size = 2'b00; bus2.req_lu = 1'b0;
    check("pre-reset d2 req_ready", 32'(bus2.req_ready), 32'd1);
    @(negedge clk);
    idle(2);
    check("busy d2 req_ready", 32'(bus2.req_ready), 32'd0);
    rst2 = 1'b1;
    #1;
    check("in-reset d2 req_ready", 32'(bus2.req_ready), 32'd1);
    @(negedge clk);
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset d2 req_ready", 32'(bus2.req_ready), 32'd1);
    issue(2, 1'b0, 32'h80, 32'h0, 2'b00, 1'b0, 32'h11112222, 1'b0, 1'b0);
    drain();

    check("d2 queue empty at end", 32'(q2.size()), 32'd0);
    check("d1 queue empty at end", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
